// File: rtl/pixel_buf_pkg.sv
// Shared types and constants for the pixel stream buffer.
// Build option: PIXEL_BUF_PARITY_EN adds a per-entry even-parity bit and a parity interrupt.
package pixel_buf_pkg;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        STREAM   = 2'd1,
        UNDERRUN = 2'd2
    } buf_state_e;

    localparam int IRQ_AE       = 0;
    localparam int IRQ_UNDERRUN = 1;
    localparam int IRQ_OVERFLOW = 2;
    localparam int IRQ_PARITY   = 3;

    // The parity flag sits just above the three base flags, so the base width equals its index.
`ifdef PIXEL_BUF_PARITY_EN
    localparam int IRQ_W = IRQ_PARITY + 1;
`else
    localparam int IRQ_W = IRQ_PARITY;
`endif

    // Widest pixel the helper accepts; narrower pixels are zero-extended, which keeps even parity.
    localparam int PIXEL_MAX_W = 64;
    typedef logic [PIXEL_MAX_W-1:0] pixel_t;

    function automatic logic parity(input pixel_t pix);
        return ^pix;
    endfunction

endpackage

// File: rtl/pixel_buf_ram.sv
// Simple dual-port pixel storage: one write port, one read port with registered output.
// The read register holds its value while rdEn is low, which lets the top stall a fetched word.
// Build option: PIXEL_BUF_PARITY_EN is handled by the top through the WIDTH parameter.
module pixel_buf_ram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 1280,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wrEn,
    input  logic [AW-1:0]    wrAddr,
    input  logic [WIDTH-1:0] wrData,
    input  logic             rdEn,
    input  logic [AW-1:0]    rdAddr,
    output logic [WIDTH-1:0] rdData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Registered read port, held when not enabled
    always_ff @(posedge clk) begin
        if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/pixel_stream_buffer.sv
// Pixel FIFO between camera/DMA writer and display/processing reader.
// Valid/ready on both sides, exact occupancy, column tracking, prefill/underrun FSM, sticky IRQs.
// Build option: PIXEL_BUF_PARITY_EN stores an even-parity bit per entry and flags mismatches
// in irq_status[IRQ_PARITY]; without it the RAM is PIXEL_W wide and irq_status is 3 bits.
//
// state    | meaning
// FILL     | waiting for level >= PREFILL at start of a line or after a clean end-of-line drain
// STREAM   | delivering pixels whenever one is staged in the output register
// UNDERRUN | ran dry mid-line; waiting for level >= PREFILL, column position kept
module pixel_stream_buffer
    import pixel_buf_pkg::*;
#(
    parameter int PIXEL_W   = 24,
    parameter int DEPTH     = 1280,
    parameter int LINE_LEN  = 640,
    parameter int PREFILL   = 320,
    parameter int AE_THRESH = 64,
    localparam int LVL_W    = $clog2(DEPTH + 1),
    localparam int COL_W    = $clog2(LINE_LEN),
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               in_ready,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] out_pixel,
    input  logic               out_ready,
    output logic [COL_W-1:0]   out_col,
    output logic               out_eol,
    output logic [LVL_W-1:0]   level,
    output logic               irq,
    output logic [IRQ_W-1:0]   irq_status,
    input  logic [IRQ_W-1:0]   irq_clr
);

`ifdef PIXEL_BUF_PARITY_EN
    localparam int RAM_W = PIXEL_W + 1;
`else
    localparam int RAM_W = PIXEL_W;
`endif

    logic               wr;
    logic               rd;
    logic [PTR_W-1:0]   wrPtr;
    logic [PTR_W-1:0]   rdPtr;
    // Entries sitting in RAM that have not yet been fetched toward the output register
    logic [LVL_W-1:0]   unissued;
    logic               rdPending;
    logic               staged;
    logic               ramRe;
    logic               loadOut;
    logic [RAM_W-1:0]   ramWrData;
    logic [RAM_W-1:0]   ramQ;
    buf_state_e         state;
    buf_state_e         stateNext;
    logic               streamEn;
    logic               underrunSet;
    logic               aeSet;
    logic               parityErr;
    logic [IRQ_W-1:0]   irqSet;

    assign in_ready  = (level != LVL_W'(DEPTH));
    assign wr        = in_valid & in_ready;
    // Gated by rst so nothing is offered during the reset cycle itself
    assign out_valid = staged & streamEn & ~rst;
    assign rd        = out_valid & out_ready;
    assign out_eol   = (out_col == COL_W'(LINE_LEN - 1));

    // Two-stage fetch: RAM read register, then output register; either may stall
    assign loadOut = rdPending & (~staged | rd);
    assign ramRe   = (unissued != '0) & (~rdPending | loadOut);

`ifdef PIXEL_BUF_PARITY_EN
    assign ramWrData = {parity(pixel_t'(in_pixel)), in_pixel};
    assign parityErr = loadOut & (^ramQ);
`else
    assign ramWrData = in_pixel;
    assign parityErr = 1'b0;
`endif

    pixel_buf_ram #(
        .WIDTH (RAM_W),
        .DEPTH (DEPTH)
    ) uRam (
        .clk    (clk),
        .wrEn   (wr),
        .wrAddr (wrPtr),
        .wrData (ramWrData),
        .rdEn   (ramRe),
        .rdAddr (rdPtr),
        .rdData (ramQ)
    );

    // Write/read pointers with explicit wrap for non-power-of-two depths
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (wr)    wrPtr <= (wrPtr == PTR_W'(DEPTH - 1)) ? '0 : wrPtr + 1'b1;
            if (ramRe) rdPtr <= (rdPtr == PTR_W'(DEPTH - 1)) ? '0 : rdPtr + 1'b1;
        end
    end

    // Occupancy as seen by the ports, plus the not-yet-fetched count used for prefetch
    always_ff @(posedge clk) begin
        if (rst) begin
            level    <= '0;
            unissued <= '0;
        end else begin
            if (wr & ~rd)      level <= level + 1'b1;
            else if (rd & ~wr) level <= level - 1'b1;
            if (wr & ~ramRe)      unissued <= unissued + 1'b1;
            else if (ramRe & ~wr) unissued <= unissued - 1'b1;
        end
    end

    // Fetch pipeline and output register; out_pixel only changes when a new word is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            rdPending <= 1'b0;
            staged    <= 1'b0;
            out_pixel <= '0;
        end else begin
            if (ramRe)        rdPending <= 1'b1;
            else if (loadOut) rdPending <= 1'b0;
            if (loadOut) begin
                staged    <= 1'b1;
                out_pixel <= ramQ[PIXEL_W-1:0];
            end else if (rd) begin
                staged    <= 1'b0;
            end
        end
    end

    // Column counter advances on each accepted output pixel
    always_ff @(posedge clk) begin
        if (rst)     out_col <= '0;
        else if (rd) out_col <= out_eol ? '0 : out_col + 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= stateNext;
    end

    // FSM next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            FILL:     if (level >= LVL_W'(PREFILL)) stateNext = STREAM;
            STREAM:   if (rd & ~wr & (level == LVL_W'(1))) stateNext = out_eol ? FILL : UNDERRUN;
            UNDERRUN: if (level >= LVL_W'(PREFILL)) stateNext = STREAM;
            default:  stateNext = FILL;
        endcase
    end

    // FSM outputs: stream gate and the event strobes that feed the interrupt flags
    always_comb begin
        streamEn    = (state == STREAM);
        underrunSet = streamEn & rd & ~wr & (level == LVL_W'(1)) & ~out_eol;
        aeSet       = streamEn & rd & ~wr & (level == LVL_W'(AE_THRESH));
    end

    // Interrupt set vector
    always_comb begin
        irqSet               = '0;
        irqSet[IRQ_AE]       = aeSet;
        irqSet[IRQ_UNDERRUN] = underrunSet;
        irqSet[IRQ_OVERFLOW] = in_valid & ~in_ready;
`ifdef PIXEL_BUF_PARITY_EN
        irqSet[IRQ_PARITY]   = parityErr;
`endif
    end

    // Sticky flags, write-1-to-clear; a new event in the same cycle wins over the clear
    always_ff @(posedge clk) begin
        if (rst) irq_status <= '0;
        else     irq_status <= (irq_status & ~irq_clr) | irqSet;
    end

    assign irq = |irq_status;

`ifndef PIXEL_BUF_PARITY_EN
    logic unusedParity;
    assign unusedParity = parityErr;
`endif

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed self-checking bench for pixel_stream_buffer with default parameters.
module tb_pixel_stream_buffer;
    import pixel_buf_pkg::*;

    localparam int PIXEL_W   = 24;
    localparam int DEPTH     = 1280;
    localparam int LINE_LEN  = 640;
    localparam int PREFILL   = 320;
    localparam int AE_THRESH = 64;
    localparam int LVL_W     = $clog2(DEPTH + 1);
    localparam int COL_W     = $clog2(LINE_LEN);

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic [PIXEL_W-1:0] in_pixel = '0;
    logic               in_ready;
    logic               out_valid;
    logic [PIXEL_W-1:0] out_pixel;
    logic               out_ready = 1'b0;
    logic [COL_W-1:0]   out_col;
    logic               out_eol;
    logic [LVL_W-1:0]   level;
    logic               irq;
    logic [IRQ_W-1:0]   irq_status;
    logic [IRQ_W-1:0]   irq_clr = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pixel_stream_buffer #(
        .PIXEL_W   (PIXEL_W),
        .DEPTH     (DEPTH),
        .LINE_LEN  (LINE_LEN),
        .PREFILL   (PREFILL),
        .AE_THRESH (AE_THRESH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_pixel   (in_pixel),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pixel  (out_pixel),
        .out_ready  (out_ready),
        .out_col    (out_col),
        .out_eol    (out_eol),
        .level      (level),
        .irq        (irq),
        .irq_status (irq_status),
        .irq_clr    (irq_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; irq_clr = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic write_n(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_pixel = PIXEL_W'(first + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic clear_irq(input logic [IRQ_W-1:0] mask);
        irq_clr = mask;
        tick();
        irq_clr = '0;
    endtask

    initial begin
        int n;
        int rdExp;
        int wrNext;
        int pl;
        logic wasRd;

        // ---- 1: reset state, prefill of 320, in-order readout ----
        do_reset();
        chk("rst_level",     32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pixel", 32'(out_pixel), 32'd0);
        chk("rst_out_col",   32'(out_col), 32'd0);
        chk("rst_in_ready",  32'(in_ready), 32'd1);
        chk("rst_irq_status",32'(irq_status), 32'd0);

        out_ready = 1'b1;
        write_n(1, 320);
        chk("t1_level_320",        32'(level), 32'd320);
        chk("t1_no_early_valid",   32'(out_valid), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("t1_out_valid_rise",   32'(out_valid), 32'd1);
        chk("t1_rise_not_early",   32'(n >= 1), 32'd1);
        rdExp = 1; n = 0;
        while (rdExp <= 320 && n < 1000) begin
            if (out_valid) begin
                chk("t1_pixel", 32'(out_pixel), 32'(rdExp));
                chk("t1_col",   32'(out_col), 32'(rdExp - 1));
                rdExp++;
            end
            tick(); n++;
        end
        chk("t1_read_count",   32'(rdExp), 32'd321);
        chk("t1_level_empty",  32'(level), 32'd0);
        chk("t1_valid_low",    32'(out_valid), 32'd0);
        chk("t1_irq_flags",    32'(irq_status), 32'h3);
        chk("t1_irq_line",     32'(irq), 32'd1);
        clear_irq('1);
        chk("t1_irq_cleared",  32'(irq_status), 32'd0);
        chk("t1_irq_line_low", 32'(irq), 32'd0);

        // ---- 2: fill to DEPTH, overflow, set-wins-over-clear ----
        do_reset();
        out_ready = 1'b0;
        write_n(1, DEPTH);
        chk("t2_level_full",   32'(level), 32'(DEPTH));
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        chk("t2_valid_held",   32'(out_valid), 32'd1);
        chk("t2_pixel_held",   32'(out_pixel), 32'd1);
        chk("t2_no_flags",     32'(irq_status), 32'd0);
        in_valid = 1'b1; in_pixel = 24'hABCDEF;
        irq_clr = '0; irq_clr[IRQ_OVERFLOW] = 1'b1;
        tick();
        in_valid = 1'b0; irq_clr = '0;
        chk("t2_overflow_set_wins", 32'(irq_status), 32'h4);
        chk("t2_level_unchanged",   32'(level), 32'(DEPTH));
        chk("t2_pixel_still_held",  32'(out_pixel), 32'd1);
        clear_irq(IRQ_W'(4));
        chk("t2_overflow_cleared",  32'(irq_status), 32'd0);

        // ---- 3: simultaneous write/read at level 500 ----
        do_reset();
        out_ready = 1'b0;
        write_n(1, 500);
        chk("t3_level_500", 32'(level), 32'd500);
        wrNext = 501; rdExp = 1;
        for (int c = 0; c < 1000; c++) begin
            in_valid = 1'b1; in_pixel = PIXEL_W'(wrNext); out_ready = 1'b1;
            if (c % 50 == 0) chk("t3_level_const", 32'(level), 32'd500);
            if (out_valid) begin
                chk("t3_pixel_order", 32'(out_pixel), 32'(rdExp));
                rdExp++;
            end
            if (in_ready) wrNext++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        chk("t3_level_end", 32'(level), 32'd500);
        chk("t3_read_count", 32'(rdExp), 32'd1001);

        // ---- mid-operation reset while streaming ----
        chk("mr_valid_before", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_valid_rst_cycle", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_valid_after", 32'(out_valid), 32'd0);
        chk("mr_level_zero",  32'(level), 32'd0);
        tick();
        chk("mr_valid_after2", 32'(out_valid), 32'd0);

        // ---- 4: run dry mid-line at column 100, then resume at 101 ----
        do_reset();
        out_ready = 1'b1;
        wrNext = 1; rdExp = 1; n = 0;
        while (rdExp <= 741 && n < 3000) begin
            in_valid = (wrNext <= 741);
            in_pixel = PIXEL_W'(wrNext);
            if (out_valid) begin
                chk("t4_pixel", 32'(out_pixel), 32'(rdExp));
                chk("t4_col",   32'(out_col), 32'((rdExp - 1) % LINE_LEN));
                rdExp++;
            end
            if (in_valid && in_ready) wrNext++;
            tick(); n++;
        end
        in_valid = 1'b0;
        chk("t4_read_count",   32'(rdExp), 32'd742);
        chk("t4_underrun_flag",32'(irq_status[IRQ_UNDERRUN]), 32'd1);
        chk("t4_col_kept",     32'(out_col), 32'd101);
        chk("t4_level_empty",  32'(level), 32'd0);
        tick(); tick(); tick();
        chk("t4_valid_low",    32'(out_valid), 32'd0);
        clear_irq('1);
        write_n(742, 320);
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        chk("t4_resumed",      32'(out_valid), 32'd1);
        chk("t4_resume_col",   32'(out_col), 32'd101);
        chk("t4_resume_pixel", 32'(out_pixel), 32'd742);
        chk("t4_no_new_flags", 32'(irq_status), 32'd0);

        // ---- 5: one exact line, clean drain at EOL, almost-empty edge ----
        do_reset();
        out_ready = 1'b0;
        write_n(1, LINE_LEN);
        chk("t5_level_640", 32'(level), 32'd640);
        out_ready = 1'b1;
        rdExp = 1; n = 0;
        while (rdExp <= LINE_LEN && n < 2000) begin
            pl = int'(level);
            wasRd = out_valid;
            if (out_valid) begin
                chk("t5_pixel", 32'(out_pixel), 32'(rdExp));
                if (rdExp == LINE_LEN - 1) chk("t5_eol_639", 32'(out_eol), 32'd0);
                if (rdExp == LINE_LEN)     chk("t5_eol_640", 32'(out_eol), 32'd1);
                rdExp++;
            end
            tick(); n++;
            if (wasRd && pl == AE_THRESH + 1) chk("t5_ae_not_yet", 32'(irq_status[IRQ_AE]), 32'd0);
            if (wasRd && pl == AE_THRESH)     chk("t5_ae_set",     32'(irq_status[IRQ_AE]), 32'd1);
        end
        chk("t5_read_count",  32'(rdExp), 32'd641);
        chk("t5_flags_ae_only", 32'(irq_status), 32'h1);
        chk("t5_level_empty", 32'(level), 32'd0);
        chk("t5_col_wrapped", 32'(out_col), 32'd0);
        chk("t5_valid_low",   32'(out_valid), 32'd0);
        write_n(1001, 5);
        tick(); tick(); tick();
        chk("t5_fill_waits",  32'(out_valid), 32'd0);
        chk("t5_level_5",     32'(level), 32'd5);
        chk("t5_no_underrun", 32'(irq_status), 32'h1);

`ifdef PIXEL_BUF_PARITY_EN
        // ---- 6: corrupted parity bit is flagged, pixel still delivered ----
        do_reset();
        out_ready = 1'b0;
        write_n(1, PREFILL);
        dut.uRam.mem[5][PIXEL_W] = ~dut.uRam.mem[5][PIXEL_W];
        chk("t6_parity_clean", 32'(irq_status[IRQ_PARITY]), 32'd0);
        out_ready = 1'b1;
        rdExp = 1; n = 0;
        while (rdExp <= 10 && n < 100) begin
            if (out_valid) begin
                chk("t6_pixel", 32'(out_pixel), 32'(rdExp));
                rdExp++;
            end
            tick(); n++;
        end
        out_ready = 1'b0;
        chk("t6_parity_flag", 32'(irq_status[IRQ_PARITY]), 32'd1);
        irq_clr = '0; irq_clr[IRQ_PARITY] = 1'b1;
        tick();
        irq_clr = '0;
        chk("t6_parity_cleared", 32'(irq_status[IRQ_PARITY]), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
